change_dispenser: RTL

- Output stage placed directly downstream of the vending-machine controller.
- Each cycle the controller's `soda` strobe is high counts as one completed sale. The block captures that sale's 3-bit change code (001=5, 010=10, 011=15, 100=20) into a small request queue.
- It then drives the physical soda-release and nickel-ejector mechanisms through req/ack handshakes, paying all change as nickels.

---
 rtl/change_dispenser.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Output stage behind the vending controller: queues completed sales and pays each one
// as a soda-release handshake followed by one nickel-ejector handshake per nickel.
module change_dispenser #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          soda_in,
    input  logic [2:0]    change_in,
    output logic          soda_req,
    input  logic          soda_ack,
    output logic          nickel_req,
    input  logic          nickel_ack,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow,
    output logic          code_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] FULL  = PW'(DEPTH);
    localparam logic [PW-1:0] ONE   = PW'(1);
    localparam logic [AW-1:0] STEP  = AW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SODA = 3'd2,
        COIN = 3'd3,
        GAP  = 3'd4
    } state_t;

    // Codes above 4 are not legal change amounts; they pay nothing.
    function automatic logic [2:0] code_to_nickels(input logic [2:0] code);
        if (code > 3'd4) begin
            return 3'd0;
        end else begin
            return code;
        end
    endfunction

    function automatic logic code_is_bad(input logic [2:0] code);
        return (code > 3'd4);
    endfunction

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    state_t        state;
    state_t        state_next;
    logic [2:0]    rem;
    logic [2:0]    rem_next;
    logic          pop;
    logic          push;
    logic          drop;

    assign pending = count;

    // Queue push/pop decisions; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop  = (state == IDLE) && (count != {PW{1'b0}});
        push = soda_in && ((count != FULL) || pop);
        drop = soda_in && !push;
    end

    // Occupancy bookkeeping.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    // Service sequencer: next state and remaining-nickel count.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        case (state)
            IDLE: begin
                if (pop) begin
                    rem_next   = mem[rd_ptr];
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: state_next = SODA;
            SODA: begin
                if (soda_ack) begin
                    state_next = (rem == 3'd0) ? IDLE : COIN;
                end else begin
                    state_next = SODA;
                end
            end
            COIN: begin
                if (nickel_ack) begin
                    rem_next   = rem - 3'd1;
                    state_next = (rem == 3'd1) ? IDLE : GAP;
                end else begin
                    state_next = COIN;
                end
            end
            GAP:     state_next = COIN;
            default: state_next = IDLE;
        endcase
    end

    // Queue storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code_to_nickels(change_in);
        end
    end

    // Control state, pointers, registered outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= 3'd0;
            wr_ptr     <= {AW{1'b0}};
            rd_ptr     <= {AW{1'b0}};
            count      <= {PW{1'b0}};
            soda_req   <= 1'b0;
            nickel_req <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state      <= state_next;
            rem        <= rem_next;
            count      <= count_next;
            soda_req   <= (state_next == SODA);
            nickel_req <= (state_next == COIN);
            busy       <= (state_next != IDLE) || (count_next != {PW{1'b0}});
            if (push) begin
                wr_ptr <= wr_ptr + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + STEP;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push && code_is_bad(change_in)) begin
                code_err <= 1'b1;
            end
        end
    end

endmodule
